// File: rtl/prog_clock_divider_pkg.sv
// clkdiv_pkg: shared defaults, half-period type and per-channel state struct for prog_clock_divider
package clkdiv_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int RESET_HALF_DEF = 5;
  localparam int HALF_MAX_W = 32;
  typedef logic [HALF_MAX_W-1:0] half_t;
  typedef struct packed {
    half_t active;
    half_t pending;
    half_t cnt;
    logic  clk_out;
    logic  tick;
  } ch_state_t;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prog_clock_divider_if.sv
// prog_clock_divider_if: write port and per-channel outputs; sync exists only with CLKDIV_SYNC_EN
interface prog_clock_divider_if
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W = CNT_W_DEF
);
  logic                     wr_en;
  logic [ch_w(NUM_CH)-1:0]  wr_ch;
  logic [CNT_W-1:0]         wr_half;
`ifdef CLKDIV_SYNC_EN
  logic                     sync;
`endif
  logic [NUM_CH-1:0]        clk_out;
  logic [NUM_CH-1:0]        tick;
  logic [NUM_CH-1:0]        upd_pending;
`ifdef CLKDIV_SYNC_EN
  modport master(output wr_en, wr_ch, wr_half, sync, input clk_out, tick, upd_pending);
  modport slave(input wr_en, wr_ch, wr_half, sync, output clk_out, tick, upd_pending);
`else
  modport master(output wr_en, wr_ch, wr_half, input clk_out, tick, upd_pending);
  modport slave(input wr_en, wr_ch, wr_half, output clk_out, tick, upd_pending);
`endif
endinterface

// File: rtl/prog_clock_divider_channel.sv
// clkdiv_channel: one divider channel; state held at the widest supported width, narrower CNT_W zero-extends
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RESET_HALF = RESET_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_half,
  input  logic             i_sync,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_upd_pending
);
  ch_state_t r_s, w_n;
  half_t     w_wr_half;
  logic      w_run, w_toggle, w_rise;
  assign w_wr_half = half_t'(i_wr_half);
  assign w_run = r_s.active != '0;
  assign w_toggle = w_run && r_s.cnt == r_s.active - half_t'(1);
  assign w_rise = w_toggle && !r_s.clk_out;
  assign o_clk_out = r_s.clk_out;
  assign o_tick = r_s.tick;
  assign o_upd_pending = r_s.pending != r_s.active;
  // next state: a zero pending only lands on the rising toggle so a stopped channel parks high
  always_comb begin
    w_n = r_s;
    w_n.pending = i_wr ? w_wr_half : r_s.pending;
    w_n.tick = w_rise && !i_sync;
    w_n.clk_out = i_sync || !w_run || (w_toggle ? !r_s.clk_out : r_s.clk_out);
    w_n.cnt = (i_sync || !w_run || w_toggle) ? '0 : r_s.cnt + half_t'(1);
    w_n.active = i_sync ? w_n.pending
               : !w_run ? r_s.pending
               : (w_toggle && (r_s.pending != '0 || w_rise)) ? r_s.pending
               : r_s.active;
  end
  // state register with synchronous reset to the power-on half-period
  always_ff @(posedge clk)
    if (rst) r_s <= '{active: half_t'(RESET_HALF), pending: half_t'(RESET_HALF), cnt: '0, clk_out: 1'b1, tick: 1'b0};
    else r_s <= w_n;
endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: multi-channel runtime-programmable divider; optional phase sync via CLKDIV_SYNC_EN
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter int RESET_HALF = RESET_HALF_DEF
) (
  input logic                 clk_in,
  input logic                 reset,
  prog_clock_divider_if.slave bus
);
  localparam int CH_W = ch_w(NUM_CH);
  logic w_sync;
`ifdef CLKDIV_SYNC_EN
  assign w_sync = bus.sync;
`else
  assign w_sync = 1'b0;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_wr;
    assign w_wr = bus.wr_en && bus.wr_ch == CH_W'(i);
    clkdiv_channel #(.CNT_W(CNT_W), .RESET_HALF(RESET_HALF)) u_ch (
      .clk          (clk_in),
      .rst          (reset),
      .i_wr         (w_wr),
      .i_wr_half    (bus.wr_half),
      .i_sync       (w_sync),
      .o_clk_out    (bus.clk_out[i]),
      .o_tick       (bus.tick[i]),
      .o_upd_pending(bus.upd_pending[i])
    );
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed checks of prog_clock_divider (3 channels, RESET_HALF 5; sync scenario with CLKDIV_SYNC_EN)
module tb_prog_clock_divider;
  logic clk, rst;
  int k, n_chk, n_fail;
  logic [2:0] ec, et, eu;
  logic [1:0] p0, p1, p2;
  prog_clock_divider_if #(.NUM_CH(3), .CNT_W(16)) bus ();
  prog_clock_divider #(.NUM_CH(3), .CNT_W(16), .RESET_HALF(5)) dut (.clk_in(clk), .reset(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [1:0] ph(input int kk, input int s, input int h);
    int j;
    j = kk - s;
    if (kk < s) return 2'b10;
    return {((j / h) % 2) == 1, j > 0 && (j % (2 * h)) == h};
  endfunction
  task automatic cyc();
    @(negedge clk);
    k++;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_ch = 2'd0;
    bus.wr_half = 16'd9;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_chk++;
      if (bus.clk_out !== 3'b111) begin n_fail++; $display("FAIL reset clk_out got %b exp 111", bus.clk_out); end
      n_chk++;
      if (bus.tick !== 3'b000) begin n_fail++; $display("FAIL reset tick got %b exp 000", bus.tick); end
      n_chk++;
      if (bus.upd_pending !== 3'b000) begin n_fail++; $display("FAIL reset upd_pending got %b exp 000", bus.upd_pending); end
    end
    rst = 1'b0;
    bus.wr_en = 1'b0;
    k = 0;
  endtask
  task automatic test_free_run();
    while (k < 20) begin
      cyc();
      p0 = ph(k, 5, 5);
      ec = {3{p0[1]}};
      et = {3{p0[0]}};
      n_chk++;
      if (bus.clk_out !== ec) begin n_fail++; $display("FAIL free_run clk_out k=%0d got %b exp %b", k, bus.clk_out, ec); end
      n_chk++;
      if (bus.tick !== et) begin n_fail++; $display("FAIL free_run tick k=%0d got %b exp %b", k, bus.tick, et); end
      n_chk++;
      if (bus.upd_pending !== 3'b000) begin n_fail++; $display("FAIL free_run upd k=%0d got %b exp 000", k, bus.upd_pending); end
    end
  endtask
  task automatic test_write_running();
    while (k < 36) begin
      bus.wr_en = (k == 20);
      bus.wr_ch = 2'd1;
      bus.wr_half = 16'd3;
      cyc();
      p0 = ph(k, 5, 5);
      p1 = ph(k, 25, 3);
      ec = {p0[1], p1[1], p0[1]};
      et = {p0[0], p1[0], p0[0]};
      eu = {1'b0, k < 25, 1'b0};
      n_chk++;
      if (bus.clk_out !== ec) begin n_fail++; $display("FAIL write_running clk_out k=%0d got %b exp %b", k, bus.clk_out, ec); end
      n_chk++;
      if (bus.tick !== et) begin n_fail++; $display("FAIL write_running tick k=%0d got %b exp %b", k, bus.tick, et); end
      n_chk++;
      if (bus.upd_pending !== eu) begin n_fail++; $display("FAIL write_running upd k=%0d got %b exp %b", k, bus.upd_pending, eu); end
    end
  endtask
  task automatic test_disable();
    while (k < 62) begin
      bus.wr_en = (k == 36) || (k == 50);
      bus.wr_ch = 2'd0;
      bus.wr_half = (k == 36) ? 16'd0 : 16'd4;
      cyc();
      p0 = (k < 40) ? ph(k, 5, 5) : ph(k, 56, 4);
      p1 = ph(k, 25, 3);
      p2 = ph(k, 5, 5);
      ec = {p2[1], p1[1], p0[1]};
      et = {p2[0], p1[0], p0[0]};
      eu = {2'b00, (k < 40) || (k == 51)};
      n_chk++;
      if (bus.clk_out !== ec) begin n_fail++; $display("FAIL disable clk_out k=%0d got %b exp %b", k, bus.clk_out, ec); end
      if (k != 40) begin
        n_chk++;
        if (bus.tick !== et) begin n_fail++; $display("FAIL disable tick k=%0d got %b exp %b", k, bus.tick, et); end
      end
      n_chk++;
      if (bus.upd_pending !== eu) begin n_fail++; $display("FAIL disable upd k=%0d got %b exp %b", k, bus.upd_pending, eu); end
    end
  endtask
  task automatic test_back_to_back();
    while (k < 90) begin
      bus.wr_en = (k == 64) || (k == 66);
      bus.wr_ch = (k == 64) ? 2'd2 : 2'd3;
      bus.wr_half = (k == 64) ? 16'd2 : 16'd1;
      cyc();
      p0 = ph(k, 56, 4);
      p1 = ph(k, 25, 3);
      p2 = (k < 72) ? ph(k, 5, 5) : ph(k, 72, 2);
      ec = {p2[1], p1[1], p0[1]};
      et = {p2[0], p1[0], p0[0]};
      eu = {(k >= 65) && (k < 70), 2'b00};
      n_chk++;
      if (bus.clk_out !== ec) begin n_fail++; $display("FAIL back_to_back clk_out k=%0d got %b exp %b", k, bus.clk_out, ec); end
      n_chk++;
      if (bus.tick !== et) begin n_fail++; $display("FAIL back_to_back tick k=%0d got %b exp %b", k, bus.tick, et); end
      n_chk++;
      if (bus.upd_pending !== eu) begin n_fail++; $display("FAIL back_to_back upd k=%0d got %b exp %b", k, bus.upd_pending, eu); end
    end
    bus.wr_en = 1'b0;
  endtask
`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    while (k < 120) begin
      bus.wr_en = (k == 90);
      bus.wr_ch = 2'd1;
      bus.wr_half = 16'd4;
      bus.sync = (k == 100);
      cyc();
      if (k > 100) begin
        p0 = ph(k, 105, 4);
        p2 = ph(k, 103, 2);
        ec = {p2[1], p0[1], p0[1]};
        et = {p2[0], p0[0], p0[0]};
        n_chk++;
        if (bus.clk_out !== ec) begin n_fail++; $display("FAIL sync clk_out k=%0d got %b exp %b", k, bus.clk_out, ec); end
        n_chk++;
        if (bus.tick !== et) begin n_fail++; $display("FAIL sync tick k=%0d got %b exp %b", k, bus.tick, et); end
        n_chk++;
        if (bus.upd_pending !== 3'b000) begin n_fail++; $display("FAIL sync upd k=%0d got %b exp 000", k, bus.upd_pending); end
      end
    end
    bus.wr_en = 1'b0;
    bus.sync = 1'b0;
  endtask
`endif
  task automatic test_reset_mid();
    bus.wr_en = 1'b1;
    bus.wr_ch = 2'd0;
    bus.wr_half = 16'd7;
    cyc();
    n_chk++;
    if (bus.upd_pending[0] !== 1'b1) begin n_fail++; $display("FAIL reset_mid upd0_before got %b exp 1", bus.upd_pending[0]); end
    rst = 1'b1;
    bus.wr_ch = 2'd1;
`ifdef CLKDIV_SYNC_EN
    bus.sync = 1'b1;
`endif
    cyc();
    n_chk++;
    if (bus.clk_out !== 3'b111) begin n_fail++; $display("FAIL reset_mid clk_out got %b exp 111", bus.clk_out); end
    n_chk++;
    if (bus.tick !== 3'b000) begin n_fail++; $display("FAIL reset_mid tick got %b exp 000", bus.tick); end
    n_chk++;
    if (bus.upd_pending !== 3'b000) begin n_fail++; $display("FAIL reset_mid upd got %b exp 000", bus.upd_pending); end
    rst = 1'b0;
    bus.wr_en = 1'b0;
`ifdef CLKDIV_SYNC_EN
    bus.sync = 1'b0;
`endif
    k = 0;
    while (k < 20) begin
      cyc();
      p0 = ph(k, 5, 5);
      ec = {3{p0[1]}};
      et = {3{p0[0]}};
      n_chk++;
      if (bus.clk_out !== ec) begin n_fail++; $display("FAIL reset_mid run clk_out k=%0d got %b exp %b", k, bus.clk_out, ec); end
      n_chk++;
      if (bus.tick !== et) begin n_fail++; $display("FAIL reset_mid run tick k=%0d got %b exp %b", k, bus.tick, et); end
      n_chk++;
      if (bus.upd_pending !== 3'b000) begin n_fail++; $display("FAIL reset_mid run upd k=%0d got %b exp 000", k, bus.upd_pending); end
    end
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    k = 0;
`ifdef CLKDIV_SYNC_EN
    bus.sync = 1'b0;
`endif
    test_reset();
    test_free_run();
    test_write_running();
    test_disable();
    test_back_to_back();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Multi-channel, runtime-programmable clock divider. It is the parametrised successor to the fixed divide-by-10 divider. Each channel produces a 50 % duty square wave `clk_out[i]` and a one-cycle `tick[i]` enable from the single system clock. Half-period values can be rewritten at run time and take effect glitch-free at a toggle boundary. The block sits beside the processor clocking logic and feeds slow peripherals (UART baud, display scan, debounce) with either a derived clock or, preferably, a clock enable.

## Interface
- `NUM_CH`, 2: number of independent channels (1..8).
- `CNT_W`, 16: width of half-period register and counter.
- `RESET_HALF`, 5: half-period loaded into every channel at reset. 5 gives 10 MHz from 100 MHz.

- `clk_in` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `wr_en` input 1: write strobe for a half-period value.
- `wr_ch` input $clog2(NUM_CH) (min 1): target channel; out-of-range writes are ignored.
- `wr_half` input CNT_W: new half-period; 0 means disable.
- `sync` input 1: phase-align all channels. Present only with `CLKDIV_SYNC_EN`.
- `clk_out` output NUM_CH: divided clocks, registered.
- `tick` output NUM_CH: one-cycle pulse coincident with each 0→1 transition of `clk_out[i]`.
- `upd_pending` output NUM_CH: high while channel i holds a written value not yet applied.

## Operation
- Per-channel registers:
  - `active` (CNT_W): the half-period in use.
  - `pending` (CNT_W): the last written half-period.
  - `cnt` (CNT_W).
  - `clk_out`, `tick`.
- Reset values: `active` = `pending` = `RESET_HALF`, `cnt` = 0, `clk_out` = 1, `tick` = 0, `upd_pending` = 0.
- Running channel (`active` ≠ 0):
  - `cnt` increments each cycle.
  - When `cnt` == `active`−1: `cnt` ← 0 and `clk_out` toggles.
  - Output period is 2·`active` cycles; duty is exactly 50 %.
- `tick[i]` = 1 for exactly the cycle in which the registered `clk_out[i]` first reads 1 after a toggle. It is never asserted on 1→0 transitions.
- Writes:
  - `wr_en` loads `pending[wr_ch]` ← `wr_half`.
  - `upd_pending[i]` = (`pending` ≠ `active`).
- Applying `pending` to `active` in a running channel:
  - A nonzero `pending` is copied into `active` at the next toggle, in either direction.
  - A zero `pending` is copied only at a 1→0→1 boundary, i.e. the toggle to high. The channel then stops with `clk_out` = 1.
  - Partial periods never occur: every half-period completes at the old value.
- Disabled channel (`active` = 0):
  - `clk_out` holds 1, `tick` = 0, `cnt` holds 0.
  - A nonzero write is copied to `active` on the following cycle, and counting starts from 0.
- Simultaneous events:
  - A write in the same cycle as a toggle updates `pending` only. The toggle applies the old `pending`, so the new value lands at the following toggle.
  - `reset` overrides everything, including a concurrent write or `sync`.
- Arithmetic: `cnt` compare is unsigned. `active` = 1 gives divide-by-2, the maximum frequency. `active` = 2^CNT_W−1 gives the maximum period.

## Timing
- No combinational path from inputs to outputs; all outputs are registered.
- After reset deasserts, with `active` = H:
  - The first 1→0 toggle is visible H cycles later.
  - The first `tick` is visible 2H cycles later.
- Write-to-effect latency, running channel: at most 2·`active` cycles.
- Write-to-effect latency, disabled channel: 1 cycle to load, then H cycles to the first falling edge.

## Configuration
- Macro: `CLKDIV_SYNC_EN`.
- With the macro defined:
  - The `sync` port exists.
  - A 1-cycle `sync` sets, in all channels at once: `cnt` ← 0, `clk_out` ← 1, `tick` ← 0, `active` ← `pending`.
  - If a write targets a channel in the same cycle, that channel's `active` ← `wr_half`.
  - Channels with equal half-periods are phase-locked afterwards.
- Without the macro: no `sync` port, and channels free-run from reset.

## Structure
- Package `clkdiv_pkg` holds:
  - Default `CNT_W` and `RESET_HALF` constants.
  - A typedef for the half-period value.
  - The per-channel state struct (`active`, `pending`, `cnt`, `clk_out`, `tick`).
- Sub-module `clkdiv_channel` implements one channel: counter, shadow register, apply rule.
- The top level decodes `wr_ch`, generates `NUM_CH` instances and fans out `reset`/`sync`.

## Test plan
- Reset, then free-run with `RESET_HALF` = 5 → `clk_out` falls 5 cycles after reset release, period 10, high 5 / low 5; `tick` is single-cycle every 10 cycles.
- Write ch1 = 3 mid-high-phase → `upd_pending[1]` = 1 until the next toggle; the current half-period completes at 5; thereafter period is 6; `upd_pending` clears on apply.
- Write ch0 = 0 while `clk_out` is low → channel stops only after returning high; `clk_out` stays 1 and `tick` stays 0. Then write 4 → counting restarts one cycle later, with the first fall 4 cycles after that.
- Write coincident with a toggle, and a write with `wr_ch` = `NUM_CH` (when NUM_CH is not a power of two) → the first is applied one toggle late; the second causes no change on any channel.
- `CLKDIV_SYNC_EN`: ch0 = 4, ch1 = 4 out of phase; pulse `sync` → both `clk_out` go 1 the next cycle, and `tick`s coincide every 8 cycles thereafter.
- Assert `reset` mid-period after writing 7 → all outputs return to their reset values the next cycle; `active` and `pending` return to 5, and the write is discarded.
